// File: rtl/spram_req_ctrl.sv
// -----------------------------------------------------------------------------
// spram_req_ctrl
//
// Request front-end that owns the address/data/write port of a single-port RAM.
// Read/write requests arrive over valid/ready and go to the RAM one per cycle,
// combinationally in the accept cycle. Reads are tracked through an
// RD_LATENCY-deep valid shift register and their data is captured into a small
// response FIFO that the consumer drains with valid/ready. Reads are only
// accepted while a FIFO slot is guaranteed, so the FIFO cannot overflow.
//
// Optional feature (macro SPRAM_REQ_CTRL_CLEAR_EN): after reset release the
// block zero-fills every RAM word (CLEAR state) before accepting requests.
// Without the macro the block accepts requests right after reset release and
// no clear counter exists.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_wr_i                  1 = write, 0 = read
//   req_addr_i/req_data_i     request address / write data
//   req_byte_valid_i          write byte enables
//   rsp_valid_o/rsp_ready_i   read response handshake
//   rsp_data_o                read response data (FIFO head)
//   busy_o                    clear running, reads in flight or FIFO non-empty
//   ram_wr_en_o, ram_data_o,
//   ram_byte_valid_o,
//   ram_addr_o                drive to the RAM
//   ram_data_i                read data from the RAM
// -----------------------------------------------------------------------------
module spram_req_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wr_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_data_i,
    input  logic [DATA_WIDTH/8-1:0] req_byte_valid_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic                    busy_o,
    output logic                    ram_wr_en_o,
    output logic [DATA_WIDTH-1:0]   ram_data_o,
    output logic [DATA_WIDTH/8-1:0] ram_byte_valid_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    input  logic [DATA_WIDTH-1:0]   ram_data_i
);

    localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
    // Wide enough for FIFO count + reads in flight + a pop allowance.
    localparam int OUT_W = $clog2(RSP_FIFO_DEPTH + RD_LATENCY + 2);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

`ifdef SPRAM_REQ_CTRL_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t                  state_reg, state_next;
    logic [RD_LATENCY-1:0]   rd_pipe_reg, rd_pipe_next;
    logic [DATA_WIDTH-1:0]   fifo_mem [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [OUT_W-1:0]        outstanding;
    logic                    run, accept, rd_accept, push, pop, credit_ok;

`ifdef SPRAM_REQ_CTRL_CLEAR_EN
    logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
`endif

    // ------------------------------------------------------------------
    // Read tracking: bit i set means a read accepted i+1 edges ago. The
    // last stage coincides with valid RAM data, so it is the FIFO push.
    // ------------------------------------------------------------------
    assign rd_pipe_next[0] = rd_accept;
    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_rd_pipe
            assign rd_pipe_next[gi] = rd_pipe_reg[gi-1];
        end
    endgenerate

    assign push        = rd_pipe_reg[RD_LATENCY-1];
    assign rsp_valid_o = (count_reg != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_data_o  = fifo_mem[rd_ptr_reg];

    // Every read in flight already owns a FIFO slot; a pop in this cycle
    // frees one, so it is counted as an extra credit.
    always_comb begin
        outstanding = OUT_W'(count_reg);
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding = outstanding + OUT_W'(rd_pipe_reg[i]);
        end
    end

    assign credit_ok = (outstanding < (OUT_W'(RSP_FIFO_DEPTH) + OUT_W'(pop)));

    // ------------------------------------------------------------------
    // Handshake and RAM drive. rst_i masks the state decode so that the
    // reset values of ready/busy/wr_en hold while reset is asserted, even
    // though the reset state itself is CLEAR or RUN.
    // ------------------------------------------------------------------
    always_comb begin
        run              = (state_reg == ST_RUN) & ~rst_i;
        req_ready_o      = run & (req_wr_i | credit_ok);
        accept           = req_valid_i & req_ready_o;
        rd_accept        = accept & ~req_wr_i;
        ram_addr_o       = req_addr_i;
        ram_data_o       = req_data_i;
        ram_byte_valid_o = req_byte_valid_i;
        ram_wr_en_o      = accept & req_wr_i;
`ifdef SPRAM_REQ_CTRL_CLEAR_EN
        if ((state_reg == ST_CLEAR) && !rst_i) begin
            ram_wr_en_o      = 1'b1;
            ram_byte_valid_o = '1;
            ram_data_o       = '0;
            ram_addr_o       = clr_cnt_reg;
        end
`endif
    end

    assign busy_o = ((state_reg == ST_CLEAR) & ~rst_i) | (|rd_pipe_reg) | (count_reg != '0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: begin
`ifdef SPRAM_REQ_CTRL_CLEAR_EN
                // Last word written when the counter is about to wrap.
                if (clr_cnt_reg == '1) begin
                    state_next = ST_RUN;
                end
`else
                state_next = ST_RUN;
`endif
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

`ifdef SPRAM_REQ_CTRL_CLEAR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_cnt_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State, tracker and FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= RESET_STATE;
            rd_pipe_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            rd_pipe_reg <= rd_pipe_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage has no reset; the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= ram_data_i;
        end
    end

    // The credit scheme makes a push into a full FIFO without a pop impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && !pop && (count_reg == CNT_W'(RSP_FIFO_DEPTH))));
        end
    end

endmodule
